// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: pipeline, memory and fill-port signals of the refill controller
interface cache_refill_ctrl_if #(
    parameter int TAG_W      = 26,
    parameter int INDEX_W    = 4,
    parameter int MISS_CNT_W = 16
);
    logic                  iReq;
    logic                  iHit;
    logic [31:0]           iAddress;
    logic                  iFlush;
    logic [INDEX_W-1:0]    iFlushIndex;
    logic                  oStall;
    logic                  oMemReq;
    logic [31:0]           oMemAddr;
    logic                  iMemGnt;
    logic                  iMemValid;
    logic [31:0]           iMemData;
    logic                  oFillEn;
    logic [INDEX_W-1:0]    oFillIndex;
    logic [TAG_W-1:0]      oFillTag;
    logic [31:0]           oFillData;
    logic [MISS_CNT_W-1:0] oMissCount;

    modport master (
        input  iReq, iHit, iAddress, iFlush, iFlushIndex, iMemGnt, iMemValid, iMemData,
        output oStall, oMemReq, oMemAddr, oFillEn, oFillIndex, oFillTag, oFillData, oMissCount
    );

    modport slave (
        output iReq, iHit, iAddress, iFlush, iFlushIndex, iMemGnt, iMemValid, iMemData,
        input  oStall, oMemReq, oMemAddr, oFillEn, oFillIndex, oFillTag, oFillData, oMissCount
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: stalls on a read miss, fetches one word from memory and fills the cache line
module cache_refill_ctrl #(
    parameter int TAG_W      = 26,
    parameter int INDEX_W    = 4,
    parameter int MISS_CNT_W = 16
) (
    input logic                 iClk,
    input logic                 iRst,
    cache_refill_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [INDEX_W-1:0]    index_q, index_d;
    logic [31:0]           data_q, data_d;
    logic                  drop_q, drop_d;
    logic [MISS_CNT_W-1:0] cnt_q, cnt_d;
    logic                  miss;
    logic                  flush_hit;

    // next state, miss latching, data capture and sticky drop of a flushed in-flight line
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        index_d   = index_q;
        data_d    = data_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        miss      = state_q == IDLE && bus.iReq && !bus.iHit && !bus.iFlush;
        flush_hit = state_q inside {REQ, WAIT, FILL} && bus.iFlush && bus.iFlushIndex == index_q;
        if (flush_hit)
            drop_d = 1'b1;
        case (state_q)
            IDLE: if (miss) begin
                state_d = REQ;
                tag_d   = bus.iAddress[31 -: TAG_W];
                index_d = bus.iAddress[2 +: INDEX_W];
                drop_d  = 1'b0;
                cnt_d   = cnt_q + {{(MISS_CNT_W-1){1'b0}}, ~&cnt_q};
            end
            REQ:  state_d = bus.iMemGnt ? WAIT : REQ;
            WAIT: if (bus.iMemValid) begin
                state_d = FILL;
                data_d  = bus.iMemData;
            end
            FILL:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // state and latched refill context; reset aborts any refill without a fill
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    // a flush hitting the line in the very fill cycle also suppresses the write
    assign bus.oStall     = miss || state_q inside {REQ, WAIT, FILL};
    assign bus.oMemReq    = state_q == REQ;
    assign bus.oMemAddr   = {tag_q, index_q, 2'b00};
    assign bus.oFillEn    = state_q == FILL && !(drop_q || flush_hit);
    assign bus.oFillIndex = index_q;
    assign bus.oFillTag   = tag_q;
    assign bus.oFillData  = data_q;
    assign bus.oMissCount = cnt_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench for the refill controller, plus a 2-bit counter instance
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cnt = 0;
    logic [31:0] addr_q[$];
    logic [61:0] fill_q[$];

    always #5 clk = ~clk;

    cache_refill_ctrl_if b();
    cache_refill_ctrl_if #(.MISS_CNT_W(2)) s();

    cache_refill_ctrl u_dut (.iClk(clk), .iRst(rst_n), .bus(b));
    cache_refill_ctrl #(.MISS_CNT_W(2)) u_sat (.iClk(clk), .iRst(rst_n), .bus(s));

    assign s.iReq        = b.iReq;
    assign s.iHit        = b.iHit;
    assign s.iAddress    = b.iAddress;
    assign s.iFlush      = b.iFlush;
    assign s.iFlushIndex = b.iFlushIndex;
    assign s.iMemGnt     = b.iMemGnt;
    assign s.iMemValid   = b.iMemValid;
    assign s.iMemData    = b.iMemData;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // memory-address and fill scoreboards, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && b.oMemReq && b.iMemGnt) begin
            if (addr_q.size() == 0) chk("addr_unexp", 64'(b.oMemReq), 64'd0);
            else chk("mem_addr", 64'(b.oMemAddr), 64'(addr_q.pop_front()));
        end
        if (b.oFillEn) begin
            if (fill_q.size() == 0) chk("fill_unexp", 64'(b.oFillEn), 64'd0);
            else chk("fill", 64'({b.oFillIndex, b.oFillTag, b.oFillData}), 64'(fill_q.pop_front()));
        end
    end

    task automatic do_miss(input logic [31:0] addr, input int gnt_dly, input int val_dly,
                           input logic [31:0] data, input bit early, input bit fl, input logic [3:0] fidx);
        bit drop;
        drop = fl && fidx == addr[5:2];
        cyc();
        b.iReq = 1'b1; b.iHit = 1'b0; b.iAddress = addr;
        #1;
        chk("miss_stall", 64'(b.oStall), 64'd1);
        addr_q.push_back({addr[31:2], 2'b00});
        cnt++;
        for (int i = 0; i <= gnt_dly; i++) begin
            cyc();
            b.iReq = 1'b0; b.iMemGnt = (i == gnt_dly); b.iMemValid = early; b.iMemData = 32'hBAD0_0000 + i;
            #1;
            chk("req", 64'({b.oStall, b.oMemReq, b.oMemAddr}), 64'({2'b11, addr[31:2], 2'b00}));
        end
        for (int i = 1; i <= val_dly; i++) begin
            cyc();
            b.iMemGnt = 1'b0; b.iMemValid = (i == val_dly);
            b.iMemData = (i == val_dly) ? data : 32'hBAD1_0000;
            b.iFlush = fl && i == 1; b.iFlushIndex = fidx;
            #1;
            chk("wait", 64'({b.oStall, b.oMemReq, b.oFillEn}), 64'd4);
            if (i == val_dly && !drop) fill_q.push_back({addr[5:2], addr[31:6], data});
        end
        cyc();
        b.iMemValid = 1'b0; b.iFlush = 1'b0;
        #1;
        chk("fill_stall", 64'(b.oStall), 64'd1);
        chk("fill_en", 64'(b.oFillEn), 64'(!drop));
        cyc();
        b.iReq = 1'b1; b.iHit = 1'b0;
        #1;
        chk("done_stall", 64'({b.oStall, b.oMemReq}), 64'd0);
        chk("miss_cnt", 64'(b.oMissCount), 64'(cnt));
        chk("sat_cnt", 64'(s.oMissCount), 64'(cnt > 3 ? 3 : cnt));
        cyc();
        b.iReq = 1'b0;
    endtask

    initial begin
        b.iReq = 1'b0; b.iHit = 1'b0; b.iAddress = '0; b.iFlush = 1'b0; b.iFlushIndex = '0;
        b.iMemGnt = 1'b0; b.iMemValid = 1'b0; b.iMemData = '0;
        cyc();
        cyc();
        chk("rst0", 64'({b.oStall, b.oMemReq, b.oFillEn, b.oMemAddr}), 64'd0);
        chk("rst0_cnt", 64'(b.oMissCount), 64'd0);
        rst_n = 1'b1;
        cyc();
        b.iReq = 1'b1; b.iHit = 1'b1;
        #1;
        chk("hit_stall", 64'({b.oStall, b.oMemReq}), 64'd0);
        b.iHit = 1'b0; b.iFlush = 1'b1;
        #1;
        chk("flush_idle", 64'(b.oStall), 64'd0);
        cyc();
        b.iReq = 1'b0; b.iFlush = 1'b0;
        #1;
        chk("flush_noreq", 64'({b.oStall, b.oMemReq}), 64'd0);
        do_miss(32'h0000_1234, 0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0);
        do_miss(32'h8765_4328, 3, 4, 32'h1357_9BDF, 1'b1, 1'b0, 4'd0);
        do_miss(32'hABCD_0014, 0, 2, 32'h5555_AAAA, 1'b0, 1'b1, 4'd5);
        do_miss(32'hABCD_0014, 0, 1, 32'h6666_BBBB, 1'b0, 1'b0, 4'd0);
        do_miss(32'h0F0F_0014, 1, 2, 32'h7777_CCCC, 1'b0, 1'b1, 4'd6);
        cyc();
        b.iReq = 1'b1; b.iHit = 1'b0; b.iAddress = 32'h0000_0ABC;
        addr_q.push_back(32'h0000_0ABC);
        cnt++;
        cyc();
        b.iReq = 1'b0; b.iMemGnt = 1'b1;
        cyc();
        b.iMemGnt = 1'b0;
        #1;
        chk("wait_pre_rst", 64'({b.oStall, b.oMemReq}), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", 64'({b.oStall, b.oMemReq, b.oFillEn, b.oMemAddr}), 64'd0);
        chk("rst_mid_fill", 64'({b.oFillIndex, b.oFillTag, b.oFillData}), 64'd0);
        chk("rst_mid_cnt", 64'({b.oMissCount, s.oMissCount}), 64'd0);
        cnt = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        b.iMemValid = 1'b1; b.iMemData = 32'hCAFE_F00D;
        #1;
        chk("stale_valid", 64'({b.oStall, b.oMemReq}), 64'd0);
        cyc();
        b.iMemValid = 1'b0;
        #1;
        chk("no_fill", 64'({b.oFillEn, b.oStall}), 64'd0);
        cyc();
        b.iReq = 1'b1; b.iHit = 1'b1;
        #1;
        chk("post_rst_hit", 64'({b.oStall, b.oMemReq}), 64'd0);
        cyc();
        b.iReq = 1'b0; b.iHit = 1'b0;
        for (int i = 0; i < 5; i++)
            do_miss(32'h0000_0100 + 32'(i * 4), 0, 1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 4'd0);
        cyc();
        cyc();
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        chk("fill_q_empty", 64'(fill_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling stage sitting directly downstream of the direct-mapped read cache's hit detection and upstream of main memory. On a cache miss it stalls the pipeline and issues a single-word read to main memory over a request/grant + valid handshake. It then writes the returned word, tag and index into the cache array and releases the stall so the access replays as a hit. It also keeps a saturating miss counter for performance monitoring.

Parameters:
TAG_W, 26, tag width (address bits 31:6)
INDEX_W, 4, set index width (address bits 5:2); cache has 2**INDEX_W lines
MISS_CNT_W, 16, width of the saturating miss counter

Ports:
iClk  in  1  clock, all state rising-edge
iRst  in  1  asynchronous, active-low reset
iReq  in  1  cache read access valid this cycle
iHit  in  1  hit result for the current access (from hit detection)
iAddress  in  32  current access address
iFlush  in  1  flush request
iFlushIndex  in  INDEX_W  line index being flushed
oStall  out  1  pipeline stall
oMemReq  out  1  main-memory read request
oMemAddr  out  32  word-aligned read address ({tag,index,2'b00})
iMemGnt  in  1  memory accepted request this cycle
iMemValid  in  1  read data valid
iMemData  in  32  read data
oFillEn  out  1  one-cycle cache line write strobe (sets valid bit)
oFillIndex  out  INDEX_W  line to write
oFillTag  out  TAG_W  tag to write
oFillData  out  32  data to write
oMissCount  out  MISS_CNT_W  number of refills started, saturating

Behaviour:
- Reset (iRst=0, async): state=IDLE. oStall, oMemReq, oFillEn=0. oMemAddr, oFillIndex, oFillTag, oFillData, oMissCount=0. Drop flag cleared.
- IDLE:
  - Miss = iReq & ~iHit & ~iFlush.
  - On miss: oStall=1 combinationally in the same cycle. Latch tag=iAddress[31:6] and index=iAddress[5:2]. Clear the drop flag. Increment oMissCount (hold at all-ones). Next state is REQ.
  - iFlush in IDLE has priority: no refill starts.
  - iMemValid/iMemGnt in IDLE are ignored.
- REQ:
  - oStall=1, oMemReq=1, oMemAddr={tag,index,2'b00}. All three hold stable until iMemGnt=1.
  - On grant, go to WAIT; oMemReq deasserts the next cycle.
  - iMemValid before grant is ignored.
- WAIT:
  - oStall=1. Wait indefinitely for iMemValid.
  - On iMemValid, register iMemData and go to FILL.
  - iMemValid in the same cycle as iMemGnt (in REQ) is NOT captured. The memory must return data no earlier than the cycle after grant.
- FILL:
  - oStall=1. oFillIndex, oFillTag and oFillData are driven from latched values.
  - oFillEn=1 for exactly this cycle unless the drop flag is set, in which case oFillEn=0.
  - Next state is DONE.
- DONE:
  - oStall=0 for one cycle so the pipeline replays the access. Misses are not detected in DONE.
  - Next state is IDLE.
  - If the fill was dropped, the replay misses again and a new refill starts normally.
- Flush during REQ/WAIT/FILL:
  - If iFlush=1 and iFlushIndex==latched index, set the drop flag (sticky until the next refill starts).
  - A non-matching flush index has no effect on the refill.
- Minimum miss latency (grant in the first REQ cycle, data the cycle after grant):
  - Miss cycle 0, REQ 1, WAIT 2, FILL 3, DONE 4.
  - oStall high in cycles 0–3.
- Reset mid-operation: the state machine aborts to IDLE with no fill. A stale iMemValid after reset is ignored.
- oMissCount increments only on the IDLE→REQ transition. It is never cleared except by reset.

Test Plan:
- Reset: assert iRst=0 mid-stream -> all outputs 0 immediately (async); after release, iReq=1,iHit=1 -> oStall=0, oMemReq=0, no fill.
- Single miss: iAddress=0x0000_1234, iHit=0, iMemGnt=1 in first REQ cycle, iMemValid=1 with 0xDEADBEEF one cycle later -> oMemAddr=0x0000_1234; oFillEn pulse at cycle 3 with index=0xD, tag=0x48, data=0xDEADBEEF; oStall high cycles 0–3; oMissCount=1.
- Handshake stalls: grant delayed 3 cycles, iMemValid asserted during REQ and again 4 cycles after grant -> oMemReq/oMemAddr stable for 4 cycles; early valid ignored; fill uses the later data.
- Flush during WAIT: miss on index 5, iFlush=1 with iFlushIndex=5 in WAIT -> oFillEn stays 0 in FILL; replay miss starts a second refill; oMissCount=2. Repeat with iFlushIndex=6 -> fill occurs.
- Counter saturation (MISS_CNT_W=2): 5 consecutive misses -> oMissCount sequence 1,2,3,3,3.
- Reset during WAIT then iMemValid=1 after release -> no oFillEn, state IDLE, oStall=0 with iReq=0.
